serial_word_collector: RTL and testbench

//  Downstream of the D-latch stage: samples the latched serial bit stream on clk
//  and assembles WIDTH-bit words.

---
 rtl/serial_word_collector.sv | 166 ++++++++++++++++
 tb/tb_serial_word_collector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Samples the latched serial bit stream on clk and assembles WIDTH-bit
//   words, delivered with a valid/ready handshake. A start that arrives while
//   a word is still pending is dropped and recorded in a sticky overrun flag.
//
//   Optional feature macro: PARITY_CHECK_EN
//     defined   : each frame carries one extra even-parity bit after the data;
//                 parity_err reports the check alongside valid.
//     undefined : frame is exactly WIDTH bits; parity_err tied to 0.
//
// Ports
//   clk        in   single clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   D          in   serial data bit
//   en         in   sample qualifier, bit taken on posedge with en=1
//   start      in   begin a new frame
//   ready      in   consumer accepts word
//   word       out  assembled word, stable while valid=1
//   valid      out  word available
//   busy       out  frame in progress
//   overrun    out  sticky: start seen while a word was pending
//   parity_err out  parity mismatch on the current word
module serial_word_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             en,
  input  logic             start,
  input  logic             ready,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef PARITY_CHECK_EN
    PAR   = 2'd2,
`endif
    HOLD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef PARITY_CHECK_EN
    perr_d    = perr_q;
`endif
    sreg_shift = MSB_FIRST ? {sreg_q[WIDTH-2:0], D} : {D, sreg_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sreg_d  = '0;
        end
      end
      SHIFT: begin
        // start is ignored mid-frame; en=0 freezes everything
        if (en) begin
          sreg_d = sreg_shift;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d = HOLD;
            word_d  = sreg_shift;
            valid_d = 1'b1;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        // D here is the even-parity bit; word is published only now
        if (en) begin
          state_d = HOLD;
          word_d  = sreg_q;
          valid_d = 1'b1;
          perr_d  = (^sreg_q) ^ D;
        end
      end
`endif
      HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
`ifdef PARITY_CHECK_EN
          perr_d  = 1'b0;
`endif
          if (start) begin
            // back-to-back frame on the accepting edge
            state_d = SHIFT;
            cnt_d   = '0;
            sreg_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign word    = word_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
`ifdef PARITY_CHECK_EN
  assign busy       = (state_q == SHIFT) || (state_q == PAR);
  assign parity_err = perr_q;
`else
  assign busy       = (state_q == SHIFT);
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench for serial_word_collector (WIDTH=8, MSB_FIRST=1).
// Expected words are queued when a frame is driven and popped by a monitor
// when the DUT hands a word over (valid && ready).
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       rst, D, en, start, ready;
  logic [7:0] word;
  logic       valid, busy, overrun, parity_err;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] w;
    logic       perr;
  } exp_t;
  exp_t sb_q[$];

  serial_word_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .D(D), .en(en), .start(start), .ready(ready),
    .word(word), .valid(valid), .busy(busy), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: a handover happens on the posedge following a negedge with valid && ready
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_word", {24'd0, word}, {24'd0, e.w});
        chk("sb_perr", {31'd0, parity_err}, {31'd0, e.perr});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one frame; do_start=0 when the frame was already started (back-to-back).
  task automatic send(input logic [7:0] w, input int gap, input logic p, input bit do_start);
    exp_t e;
    e.w = w;
`ifdef PARITY_CHECK_EN
    e.perr = (^w) ^ p;
`else
    e.perr = 1'b0;
`endif
    sb_q.push_back(e);
    if (do_start) begin
      start = 1'b1; tick(); start = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; D = w[7-i];
      if (i == 7) chk("valid_early", {31'd0, valid}, 0);
      tick();
      en = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        if (i < 7) chk("busy_gap", {31'd0, busy}, 1);
      end
    end
`ifdef PARITY_CHECK_EN
    en = 1'b1; D = p; tick(); en = 1'b0;
`endif
    chk("valid_lat", {31'd0, valid}, 1);
    chk("busy_hold", {31'd0, busy}, 0);
  endtask

  // Accept the pending word, optionally starting the next frame on the same edge.
  task automatic accept(input bit with_start);
    int t = 0;
    while (!valid && t < 50) begin tick(); t++; end
    if (!valid) chk("accept_timeout", 1, 0);
    ready = 1'b1; start = with_start;
    tick();
    ready = 1'b0; start = 1'b0;
    chk("valid_drop", {31'd0, valid}, 0);
  endtask

  initial begin
    rst = 1'b1; D = 1'b0; en = 1'b0; start = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    // 1: reset state
    chk("rst_word",  {24'd0, word}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_ovr",   {31'd0, overrun}, 0);
    chk("rst_perr",  {31'd0, parity_err}, 0);

    // 2: basic frame
    send(8'hB2, 0, 1'b0, 1'b1);
    chk("t2_word", {24'd0, word}, 32'hB2);
    accept(1'b0);
    tick();
    chk("t2_idle_busy", {31'd0, busy}, 0);

    // 3: en gaps between bits
    send(8'hB2, 2, 1'b0, 1'b1);
    accept(1'b0);

    // 4: overrun
    send(8'h3C, 0, 1'b0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_ovr",   {31'd0, overrun}, 1);
    chk("t4_valid", {31'd0, valid}, 1);
    chk("t4_word",  {24'd0, word}, 32'h3C);
    chk("t4_busy",  {31'd0, busy}, 0);
    tick();
    accept(1'b0);
    repeat (2) tick();
    chk("t4_idle", {31'd0, busy}, 0);
    chk("t4_ovr_sticky", {31'd0, overrun}, 1);
    send(8'hC3, 0, 1'b0, 1'b1);
    chk("t4_ovr_still", {31'd0, overrun}, 1);
    accept(1'b0);

    // 5: reset mid-frame
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin en = 1'b1; D = i[0]; tick(); end
    en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_ovr_clr", {31'd0, overrun}, 0);
    for (int i = 0; i < 12; i++) begin
      en = 1'b1; D = 1'b1; tick();
      chk("t5_no_valid", {31'd0, valid}, 0);
    end
    en = 1'b0;
    chk("t5_busy", {31'd0, busy}, 0);
    send(8'h5A, 0, 1'b0, 1'b1);
    accept(1'b1);                 // back-to-back: next frame starts on accept
    chk("b2b_busy", {31'd0, busy}, 1);
    send(8'hE7, 1, 1'b1, 1'b0);
    accept(1'b0);

    // 6: parity
    send(8'hB2, 0, 1'b0, 1'b1);
    chk("t6_perr0", {31'd0, parity_err}, 0);
    accept(1'b0);
    send(8'hB2, 0, 1'b1, 1'b1);
`ifdef PARITY_CHECK_EN
    chk("t6_perr1", {31'd0, parity_err}, 1);
`else
    chk("t6_perr1", {31'd0, parity_err}, 0);
`endif
    accept(1'b0);
    chk("t6_perr_clr", {31'd0, parity_err}, 0);

    repeat (2) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
